fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised successor to the single-entry instruction fetch stage (STAGE 1 FETCH) of the RV32I 5-stage pipeline.
- Decouples instruction-memory latency from decode with a QUEUE_DEPTH-entry prefetch queue of {pc, instr} pairs.
- Presents one registered instruction per cycle to decode.
- Redirects (writeback trap/return, execute branch/jump) squash queue contents and restart fetch at the target.

Parameters:
- PC_RESET, 0: first fetch address after reset.
- XLEN, 32: PC/address width; instructions are always 32 bits.
- QUEUE_DEPTH, 4: prefetch queue entries; power of 2, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- imem_addr  out  XLEN  instruction memory address.
- imem_req  out  1  fetch request.
- imem_ack  in  1  response valid; imem_rdata is valid in the same cycle as req&&ack.
- imem_rdata  in  32  instruction word.
- writeback_change_pc  in  1  trap/return redirect.
- writeback_next_pc  in  XLEN  trap/return target.
- execute_change_pc  in  1  branch/jump redirect.
- execute_next_pc  in  XLEN  branch/jump target.
- stall  in  1  hold output register.
- flush  in  1  squash output register.
- fetch_valid  out  1  output register holds a live instruction (clock-enable for decode).
- fetch_instr  out  32  instruction to decode.
- pc  out  XLEN  PC of fetch_instr.
- queue_level  out  $clog2(QUEUE_DEPTH)+1  current occupancy.

Behaviour:
- Reset (async): fetch_pc=PC_RESET, imem_addr=PC_RESET, imem_req=0, queue empty, queue_level=0, fetch_valid=0, fetch_instr=0, pc=0.
- imem_req is registered. It rises the first cycle after reset release.
- imem_req is high whenever queue_level + (req pending) < QUEUE_DEPTH and no redirect is occurring that cycle.
- imem_addr and imem_req hold stable while req && !ack.
- On req&&ack with no redirect:
  - push {imem_addr, imem_rdata}.
  - imem_addr <= imem_addr+4 (wraps modulo 2^XLEN).
  - req stays high if space remains after the push.
- Output register load condition: !stall || !fetch_valid.
  - Queue non-empty: pop head into pc/fetch_instr, fetch_valid=1.
  - Queue empty: fetch_valid=0.
- stall=1 with fetch_valid=1: outputs frozen, no pop. The queue continues filling until full, then req drops.
- flush=1 and !stall: fetch_valid<=0 next edge, no pop that cycle.
- flush=1 and stall=1: no effect; stall has priority.
- Redirect: writeback_change_pc has priority over execute_change_pc.
  - Independent of stall, the queue is cleared (level=0).
  - A response accepted in the redirect cycle is discarded.
  - fetch_valid<=0.
  - imem_addr<=target, imem_req<=1 the next cycle.
  - A pending unacked request is abandoned; memory must tolerate an address change while req is high.
- Push and pop in the same cycle: level unchanged. Pointers wrap modulo QUEUE_DEPTH.
- Full queue: req=0 until a pop.
- Empty queue: fetch_valid drops after the current instruction is consumed (bubble).
- Latency, zero-wait memory, no bypass:
  - Reset release at edge 0; req at cycle 1; push at edge 2; fetch_valid at edge 3.
  - Steady state: throughput 1 instruction/cycle.
- Target misalignment is not checked (pc[1:0] passes through).

Optional Feature:
- FETCH_BYPASS_EN.
  - Defined: when the queue is empty and the output register loads, a fresh req&&ack response goes directly to the output register without a push. This saves one cycle after reset, redirect or underflow; first fetch_valid at edge 2.
  - Undefined: every response passes through the queue.
  - Redirect and flush rules are identical in both builds.

Decomposition:
- Package fetch_pkg holds:
  - fetch_entry_t struct {logic [XLEN-1:0] pc; logic [31:0] instr} (parametrised via a localparam default).
  - INSTR_W=32.
  - PC_STEP=4.
  - redirect_src_e enum {REDIR_NONE, REDIR_EXEC, REDIR_WB}.
- One sub-module, fetch_fifo: synchronous FIFO with synchronous clear, push/pop, full/empty, level.
- The top level holds the request FSM, redirect mux and output register.

Test Plan:
- Reset, PC_RESET=0, ack always 1, rdata=addr -> imem_addr 0,4,8,...; fetch_valid at edge 3 (edge 2 with FETCH_BYPASS_EN); pc/instr 0,4,8 on consecutive cycles.
- stall held 6 cycles, DEPTH=4 -> outputs frozen; queue_level reaches 4; imem_req drops. Release stall -> pc continues sequentially with no gap or duplicate.
- ack low 3 cycles with req high -> imem_addr stable. Queue drains; fetch_valid=0 bubble once empty; resumes after ack.
- execute_change_pc=1, target 0x100, in the same cycle as an ack -> that response dropped; queue_level=0; next req at 0x100; first valid pc=0x100.
- writeback and execute redirect in the same cycle (0x80 vs 0x200) -> fetch restarts at 0x80. Also check redirect during stall=1 clears the queue.
- flush=1, stall=0 -> fetch_valid=0 next cycle, head not popped. flush=1 with stall=1 -> no change.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned PC_STEP  = 4;
  localparam int unsigned XLEN_DEF = 32;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_EXEC = 2'd1,
    REDIR_WB   = 2'd2
  } redirect_src_e;

  typedef enum logic {
    REQ_IDLE   = 1'b0,
    REQ_ACTIVE = 1'b1
  } req_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous clear; head word is visible combinationally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (level == LW'(DEPTH));
  assign empty_c = (level == '0);
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end

  // Storage needs no reset; occupancy is tracked by level.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch stage: request FSM, redirect mux, queue and output register.
// Optional FETCH_BYPASS_EN lets a fresh response skip an empty queue straight to the output.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int unsigned QUEUE_DEPTH = 4,
  localparam int unsigned LW = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic [XLEN-1:0]    imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               writeback_change_pc,
  input  logic [XLEN-1:0]    writeback_next_pc,
  input  logic               execute_change_pc,
  input  logic [XLEN-1:0]    execute_next_pc,
  input  logic               stall,
  input  logic               flush,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic [XLEN-1:0]    pc,
  output logic [LW-1:0]      queue_level
);

  localparam int unsigned EW = XLEN + INSTR_W;

  req_state_e         state_q, state_n;
  logic [XLEN-1:0]    addr_n;
  redirect_src_e      redir_src;
  logic [XLEN-1:0]    redir_target;
  logic               redirect;
  logic               accept;
  logic               out_load;
  logic               take;
  logic               bypass;
  logic               push;
  logic               pop;
  logic [EW-1:0]      fifo_head_c;
  logic               fifo_full_c;
  logic               fifo_empty_c;
  logic [LW-1:0]      level_next;
  logic               valid_n;
  logic [XLEN-1:0]    pc_n;
  logic [INSTR_W-1:0] instr_n;

  // Writeback redirects win over execute redirects.
  always_comb begin
    redir_src    = REDIR_NONE;
    redir_target = writeback_next_pc;
    if (writeback_change_pc) begin
      redir_src    = REDIR_WB;
      redir_target = writeback_next_pc;
    end else if (execute_change_pc) begin
      redir_src    = REDIR_EXEC;
      redir_target = execute_next_pc;
    end
  end

  assign redirect = (redir_src != REDIR_NONE);
  assign accept   = imem_req && imem_ack && !redirect;
  assign out_load = !stall || !fetch_valid;
  assign take     = out_load && !flush && !redirect;

`ifdef FETCH_BYPASS_EN
  assign bypass = take && fifo_empty_c && accept;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !bypass && !fifo_full_c;
  assign pop  = take && !fifo_empty_c;

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (redirect),
    .push    (push),
    .pop     (pop),
    .wdata   ({imem_addr, imem_rdata}),
    .head_c  (fifo_head_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .level   (queue_level)
  );

  // Occupancy after this cycle's push/pop decides whether another request fits.
  always_comb begin
    level_next = queue_level;
    if (push && !pop)      level_next = queue_level + LW'(1);
    else if (pop && !push) level_next = queue_level - LW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= REQ_IDLE;
      imem_addr <= PC_RESET;
    end else begin
      state_q   <= state_n;
      imem_addr <= addr_n;
    end
  end

  // Request FSM: hold address while waiting for ack, advance on ack, restart on redirect.
  always_comb begin
    state_n = state_q;
    addr_n  = imem_addr;
    if (redirect) begin
      state_n = REQ_ACTIVE;
      addr_n  = redir_target;
    end else begin
      case (state_q)
        REQ_IDLE: begin
          if (level_next < LW'(QUEUE_DEPTH)) state_n = REQ_ACTIVE;
        end
        REQ_ACTIVE: begin
          if (imem_ack) begin
            addr_n = imem_addr + XLEN'(PC_STEP);
            if (level_next >= LW'(QUEUE_DEPTH)) state_n = REQ_IDLE;
          end
        end
        default: state_n = REQ_IDLE;
      endcase
    end
  end

  assign imem_req = (state_q == REQ_ACTIVE);

  // Output register: redirect kills, stall holds, flush inserts a bubble without popping.
  always_comb begin
    valid_n = fetch_valid;
    pc_n    = pc;
    instr_n = fetch_instr;
    if (redirect) begin
      valid_n = 1'b0;
    end else if (out_load) begin
      if (flush) begin
        valid_n = 1'b0;
      end else if (!fifo_empty_c) begin
        valid_n = 1'b1;
        pc_n    = fifo_head_c[EW-1:INSTR_W];
        instr_n = fifo_head_c[INSTR_W-1:0];
      end else if (bypass) begin
        valid_n = 1'b1;
        pc_n    = imem_addr;
        instr_n = imem_rdata;
      end else begin
        valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid <= 1'b0;
      fetch_instr <= '0;
      pc          <= '0;
    end else begin
      fetch_valid <= valid_n;
      fetch_instr <= instr_n;
      pc          <= pc_n;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a zero-wait memory model returning addr ^ IMASK.
module tb_fetch_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam logic [31:0] IMASK = 32'hDEAD_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] imem_addr;
  logic            imem_req;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            writeback_change_pc;
  logic [XLEN-1:0] writeback_next_pc;
  logic            execute_change_pc;
  logic [XLEN-1:0] execute_next_pc;
  logic            stall;
  logic            flush;
  logic            fetch_valid;
  logic [31:0]     fetch_instr;
  logic [XLEN-1:0] pc;
  logic [LW-1:0]   queue_level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ IMASK;

  fetch_queue #(
    .XLEN        (XLEN),
    .PC_RESET    (32'h0),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .imem_addr           (imem_addr),
    .imem_req            (imem_req),
    .imem_ack            (imem_ack),
    .imem_rdata          (imem_rdata),
    .writeback_change_pc (writeback_change_pc),
    .writeback_next_pc   (writeback_next_pc),
    .execute_change_pc   (execute_change_pc),
    .execute_next_pc     (execute_next_pc),
    .stall               (stall),
    .flush               (flush),
    .fetch_valid         (fetch_valid),
    .fetch_instr         (fetch_instr),
    .pc                  (pc),
    .queue_level         (queue_level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] exp_pc);
    chk({tag, "_valid"}, 32'(fetch_valid), 32'd1);
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_instr"}, fetch_instr, exp_pc ^ IMASK);
  endtask

  initial begin
    rst                 = 1'b1;
    imem_ack            = 1'b1;
    writeback_change_pc = 1'b0;
    writeback_next_pc   = '0;
    execute_change_pc   = 1'b0;
    execute_next_pc     = '0;
    stall               = 1'b0;
    flush               = 1'b0;

    step();
    step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_instr", fetch_instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_level", 32'(queue_level), 32'd0);
    rst = 1'b0;

    // Startup latency and sequential fetch
    step();
    chk("e1_req", 32'(imem_req), 32'd1);
    chk("e1_addr", imem_addr, 32'h0);
    chk("e1_valid", 32'(fetch_valid), 32'd0);
    for (int e = 2; e <= 5; e++) begin
      step();
      if (e >= 3 - BYP) chk_out("seq", 32'(4 * (e - (3 - BYP))));
      else chk("seq_early_valid", 32'(fetch_valid), 32'd0);
    end
    chk("seq_level", 32'(queue_level), 32'(1 - BYP));

    // Stall fills the queue and drops req
    stall = 1'b1;
    repeat (6) begin
      step();
      chk_out("stall", 32'h8);
    end
    chk("stall_level", 32'(queue_level), 32'd4);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_addr", imem_addr, 32'd28);
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("unstall", 32'(12 + 4 * i));
    end

    // Memory wait: address holds, queue drains to a bubble
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, 32'd44);
      chk_out("wait", 32'(32 + 4 * i));
    end
    step();
    chk("bubble_valid", 32'(fetch_valid), 32'd0);
    chk("bubble_addr", imem_addr, 32'd44);
    chk("bubble_level", 32'(queue_level), 32'd0);
    imem_ack = 1'b1;
    step();
    chk("resume_valid", 32'(fetch_valid), 32'(BYP));
    step();
    chk_out("resume", 32'(44 + 4 * BYP));

    // Execute redirect in an ack cycle
    execute_change_pc = 1'b1;
    execute_next_pc   = 32'h100;
    step();
    execute_change_pc = 1'b0;
    chk("exr_valid", 32'(fetch_valid), 32'd0);
    chk("exr_level", 32'(queue_level), 32'd0);
    chk("exr_addr", imem_addr, 32'h100);
    chk("exr_req", 32'(imem_req), 32'd1);
    step();
    chk("exr_first_valid", 32'(fetch_valid), 32'(BYP));
    step();
    chk_out("exr", 32'(32'h100 + 4 * BYP));

    // Writeback beats execute
    writeback_change_pc = 1'b1;
    writeback_next_pc   = 32'h80;
    execute_change_pc   = 1'b1;
    execute_next_pc     = 32'h200;
    step();
    writeback_change_pc = 1'b0;
    execute_change_pc   = 1'b0;
    chk("prio_addr", imem_addr, 32'h80);
    chk("prio_valid", 32'(fetch_valid), 32'd0);
    step();
    step();
    chk_out("prio", 32'(32'h80 + 4 * BYP));

    // Redirect under stall clears the queue
    stall = 1'b1;
    step();
    step();
    chk("stred_pre_level", 32'(queue_level), 32'(3 - BYP));
    chk_out("stred_frozen", 32'(32'h80 + 4 * BYP));
    execute_change_pc = 1'b1;
    execute_next_pc   = 32'h40;
    step();
    execute_change_pc = 1'b0;
    chk("stred_level", 32'(queue_level), 32'd0);
    chk("stred_valid", 32'(fetch_valid), 32'd0);
    chk("stred_addr", imem_addr, 32'h40);
    step();
    chk("stred_e1_valid", 32'(fetch_valid), 32'(BYP));
    step();
    chk_out("stred", 32'h40);

    // Flush without stall: bubble, head kept
    stall = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", 32'(fetch_valid), 32'd0);
    chk("flush_level", 32'(queue_level), 32'd2);
    step();
    chk_out("flush_next", 32'h44);

    // Flush under stall has no effect
    flush = 1'b1;
    stall = 1'b1;
    step();
    flush = 1'b0;
    stall = 1'b0;
    chk_out("flush_stall", 32'h44);
    chk("flush_stall_level", 32'(queue_level), 32'd3);
    step();
    chk_out("flush_stall_next", 32'h48);

    // Address wrap at the top of the address space
    execute_change_pc = 1'b1;
    execute_next_pc   = 32'hFFFF_FFF8;
    step();
    execute_change_pc = 1'b0;
    chk("wrap_a0", imem_addr, 32'hFFFF_FFF8);
    step();
    chk("wrap_a1", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_a2", imem_addr, 32'h0);
    step();
    step();
    chk_out("wrap", 32'(4 * BYP));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
